// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and default width for the HI/LO multiply/divide unit.
package muldiv_pkg;
    localparam int WIDTH_DEF = 32;
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_e;
    function automatic logic is_signed_op(input logic [2:0] op);
        return op == OP_MULT || op == OP_DIV;
    endfunction
endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: 2*WIDTH accumulator with one shift-add or restoring shift-subtract step per cycle.
module muldiv_datapath #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc
);
    logic [WIDTH-1:0] d;
    logic [WIDTH:0]   sum, rem_sh, diff;
    always_comb begin
        sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, d} : '0);
        rem_sh = acc[2*WIDTH-1:WIDTH-1];
        diff   = rem_sh - {1'b0, d};
    end
    // Multiply keeps the multiplier in the low half and shifts it out LSB first;
    // divide shifts the dividend into the remainder half and quotient bits in at bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            d   <= '0;
        end else if (load) begin
            acc <= {{WIDTH{1'b0}}, a};
            d   <= b;
        end else if (step) begin
            acc <= !is_div ? {sum, acc[WIDTH-1:1]} :
                   diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} :
                   {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: iterative MULT/DIV control, sign correction and architectural HI/LO registers.
module muldiv_hilo_unit import muldiv_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Busy,
    output logic             Done
);
    localparam int CW = $clog2(WIDTH);
    state_e state, state_n;
    logic [CW-1:0] cnt;
    logic is_div, neg_q, neg_r, b_zero, sgn, load, step;
    logic [WIDTH-1:0] a_abs, b_abs, quo, rem;
    logic [2*WIDTH-1:0] acc, prod;
    always_comb begin
        sgn     = is_signed_op(Op);
        a_abs   = sgn && A[WIDTH-1] ? -A : A;
        b_abs   = sgn && B[WIDTH-1] ? -B : B;
        load    = state == S_IDLE && Start && !Op[2];
        step    = state == S_RUN;
        state_n = state == S_IDLE ? (load ? S_RUN : S_IDLE) :
                  state == S_RUN  ? (cnt == CW'(WIDTH - 1) ? S_FIX : S_RUN) :
                  state == S_FIX  ? S_DONE : S_IDLE;
        prod    = neg_q ? -acc : acc;
        // Divide by zero yields an all-ones quotient; the remainder sign fix restores raw A.
        quo     = b_zero ? '1 : neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem     = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        Busy    = state != S_IDLE;
    end
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            HI     <= '0;
            LO     <= '0;
            Done   <= 1'b0;
        end else begin
            state <= state_n;
            Done  <= state == S_FIX;
            cnt   <= step ? cnt + 1'b1 : '0;
            if (load) begin
                is_div <= Op[1];
                neg_q  <= sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
                neg_r  <= sgn && A[WIDTH-1];
                b_zero <= B == '0;
            end
            if (state == S_FIX) begin
                HI <= is_div ? rem : prod[2*WIDTH-1:WIDTH];
                LO <= is_div ? quo : prod[WIDTH-1:0];
            end else if (state == S_IDLE && Start && Op == OP_MTHI) begin
                HI <= A;
            end else if (state == S_IDLE && Start && Op == OP_MTLO) begin
                LO <= A;
            end
        end
    end
    muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk(Clk), .rst(Reset), .load(load), .step(step), .is_div(is_div),
        .a(a_abs), .b(b_abs), .acc(acc)
    );
endmodule

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath. Sits directly downstream of the register file and consumes its PA/PB read ports as operands. Its HI/LO outputs feed the MFHI/MFLO path back into PW of the register file. Busy drives the pipeline stall for MFHI/MFLO and for a new MULT/DIV.

Parameters:
WIDTH, 32, operand width. HI and LO are each WIDTH bits; the product is 2*WIDTH bits.
ITER, WIDTH, number of iteration cycles. Fixed equal to WIDTH and not independently settable.

Ports:
Clk  input  1  clock; all state changes on the rising edge.
Reset  input  1  asynchronous, active-high reset.
Start  input  1  request, sampled on the rising edge.
Op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are no-ops.
A  input  WIDTH  operand from register-file PA (rs).
B  input  WIDTH  operand from register-file PB (rt).
HI  output  WIDTH  architectural HI register.
LO  output  WIDTH  architectural LO register.
Busy  output  1  high while state is not IDLE; combinational decode of state.
Done  output  1  registered one-cycle pulse when HI/LO receive a MULT/DIV result.

Behaviour:
- Reset (asynchronous, any time, including mid-operation): state=IDLE, HI=0, LO=0, Done=0, Busy=0, counter=0. Any in-flight operation is discarded.
- States: IDLE, RUN, FIX, DONE.
- IDLE, Start=1, Op in 0..3 at edge k: latch |A| and |B| (raw values for unsigned ops), the sign flags and Op; counter=0; go to RUN.
- IDLE, Start=1, Op=4: HI<=A at edge k. Op=5: LO<=A at edge k. In both cases stay in IDLE; Busy and Done stay 0.
- IDLE, Start=1, Op=6/7: no effect.
- RUN: one iteration per edge, at edges k+1 .. k+WIDTH.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; quotient bits are shifted into the low half and the partial remainder is kept in the high half.
  - Counter increments each iteration; at counter=WIDTH-1 the next state is FIX.
- FIX (edge k+WIDTH+1): apply sign correction and write HI/LO; go to DONE; Done<=1.
  - Signed MULT: negate the 64-bit product if the operand signs differ.
  - Signed DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend; quotient truncates toward zero.
  - MULT/MULTU: HI=product[63:32], LO=product[31:0]. DIV/DIVU: LO=quotient, HI=remainder.
- DONE (edge k+WIDTH+2): go to IDLE; Done<=0.
- Timing summary: Busy is high for exactly WIDTH+2 cycles (34 for WIDTH=32). HI/LO are visible the cycle after the FIX edge, coincident with Done=1.
- Start while Busy: ignored for all Op values, including MTHI/MTLO. HI/LO keep their old values until the FIX edge.
- Divide by zero (B=0, DIV or DIVU): LO=FFFF_FFFF, HI=A (raw, no sign fix). Full latency still applies.
- Signed overflow: DIV of 8000_0000 by FFFF_FFFF gives LO=8000_0000, HI=0 (wraps, no exception).
- A/B are only sampled at the accepting edge. Changes on PA/PB during RUN have no effect.

Decomposition:
- Shared package muldiv_pkg holds:
  - Op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO.
  - State encodings: S_IDLE, S_RUN, S_FIX, S_DONE.
  - WIDTH default.
- Sub-module muldiv_datapath holds the 2*WIDTH accumulator, the divisor/multiplicand register and the per-iteration add/subtract logic, with controls load, step, is_div.
- Top level holds the FSM, counter, sign flags, FIX correction and the HI/LO registers.

Test Plan:
- Reset, then MULTU A=0000_0003, B=0000_0005 -> Busy high for 34 cycles; Done pulse; HI=0, LO=0000_000F.
- MULT A=FFFF_FFFE (-2), B=0000_0007 -> HI=FFFF_FFFF, LO=FFFF_FFF2. Then MULTU FFFF_FFFF x FFFF_FFFF -> HI=FFFF_FFFE, LO=0000_0001.
- DIV A=FFFF_FFF9 (-7), B=0000_0002 -> LO=FFFF_FFFD (-3), HI=FFFF_FFFF (-1). DIVU 0000_0064 / 0000_0007 -> LO=0000_000E, HI=0000_0002.
- DIVU A=1234_5678, B=0 -> LO=FFFF_FFFF, HI=1234_5678. Signed DIV 8000_0000 / FFFF_FFFF -> LO=8000_0000, HI=0.
- MTHI A=AAAA_AAAA, then MTLO A=5555_5555 -> HI/LO updated on the next edge with Busy=0. Issue MTLO 0000_0001 during a running MULT -> ignored; LO takes the MULT result.
- Assert Reset at cycle 10 of a DIV -> Busy, Done, HI and LO go to 0 immediately. A new MULTU 2x2 after release -> LO=0000_0004 after 34 cycles.
